// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-side branch predictor. A direct-mapped table of 2-bit
//               saturating counters sits alongside a branch target buffer.
//               The table is trained from EX-stage resolved outcomes. A
//               registered one-cycle mispredict/redirect pulse drives the PC
//               and flush logic.
//               Optional macro BP_STATS_EN adds branch and mispredict
//               statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int         IDX_BITS = 4,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic        res_is_branch,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic [ENTRIES-1:0]            valid_q,  valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q,    tag_d;
    logic [ENTRIES-1:0][31:0]      target_q, target_d;
    logic [ENTRIES-1:0][1:0]       ctr_q,    ctr_d;
    logic                          mispredict_q,  mispredict_d;
    logic [31:0]                   redirect_pc_q, redirect_pc_d;

    logic [IDX_BITS-1:0] w_fetch_idx;
    logic [TAG_W-1:0]    w_fetch_tag;
    logic                w_fetch_hit;
    logic [IDX_BITS-1:0] w_res_idx;
    logic [TAG_W-1:0]    w_res_tag;
    logic                w_res_hit;
    logic                w_res_br;
    logic                w_mis;

    assign w_fetch_idx = fetch_pc[IDX_BITS+1:2];
    assign w_fetch_tag = fetch_pc[31:IDX_BITS+2];
    assign w_res_idx   = res_pc[IDX_BITS+1:2];
    assign w_res_tag   = res_pc[31:IDX_BITS+2];
    assign w_res_br    = res_valid & res_is_branch;

    // Lookup reads the registered table only, so a same-cycle update is not bypassed
    always_comb begin
        w_fetch_hit = valid_q[w_fetch_idx] && (tag_q[w_fetch_idx] == w_fetch_tag);
        pred_taken  = w_fetch_hit && ctr_q[w_fetch_idx][1];
        pred_target = pred_taken ? target_q[w_fetch_idx] : (fetch_pc + 32'd4);
    end

    // Train the entry addressed by the resolved branch
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        w_res_hit = valid_q[w_res_idx] && (tag_q[w_res_idx] == w_res_tag);
        if (w_res_br) begin
            if (w_res_hit) begin
                if (res_taken) begin
                    if (ctr_q[w_res_idx] != 2'b11) begin
                        ctr_d[w_res_idx] = ctr_q[w_res_idx] + 2'd1;
                    end
                    target_d[w_res_idx] = res_target;
                end else if (ctr_q[w_res_idx] != 2'b00) begin
                    ctr_d[w_res_idx] = ctr_q[w_res_idx] - 2'd1;
                end
            end else if (res_taken) begin
                // Allocation replaces any aliasing branch in this slot
                valid_d[w_res_idx]  = 1'b1;
                tag_d[w_res_idx]    = w_res_tag;
                target_d[w_res_idx] = res_target;
                ctr_d[w_res_idx]    = 2'b10;
            end
        end
    end

    // Detect a wrong direction or wrong taken target and form the redirect
    always_comb begin
        w_mis = w_res_br & ((res_taken != res_pred_taken) |
                            (res_taken & (res_pred_target != res_target)));
        mispredict_d  = w_mis;
        redirect_pc_d = redirect_pc_q;
        if (w_mis) begin
            redirect_pc_d = res_taken ? res_target : (res_pc + 32'd4);
        end
    end

    // Table and redirect state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            tag_q         <= '0;
            target_q      <= '0;
            ctr_q         <= {ENTRIES{CTR_INIT}};
            mispredict_q  <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q,    stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Free-running wrap-around event counters
    always_comb begin
        stat_branches_d    = stat_branches_q    + {31'd0, w_res_br};
        stat_mispredicts_d = stat_mispredicts_q + {31'd0, w_mis};
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor
//               (IDX_BITS=4, CTR_INIT=2'b01).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_is_branch;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    branch_predictor #(
        .IDX_BITS (4),
        .CTR_INIT (2'b01)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_valid       (res_valid),
        .res_is_branch   (res_is_branch),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one resolve for a single clock edge, then leave the slot idle
    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt, input logic is_br);
        res_valid       = 1'b1;
        res_is_branch   = is_br;
        res_pc          = pc;
        res_taken       = tk;
        res_target      = tgt;
        res_pred_taken  = ptk;
        res_pred_target = ptgt;
        @(posedge clk);
        #1;
        res_valid     = 1'b0;
        res_is_branch = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        fetch_pc        = 32'd0;
        res_valid       = 1'b0;
        res_is_branch   = 1'b0;
        res_pc          = 32'd0;
        res_taken       = 1'b0;
        res_target      = 32'd0;
        res_pred_taken  = 1'b0;
        res_pred_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        // 1: reset state
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        fetch_pc = 32'h0040_0010;
        #1;
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h0040_0014);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2: first taken resolve allocates and mispredicts
        resolve(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014, 1'b1);
        chk("s2_mispredict", {31'd0, mispredict}, 32'd1);
        chk("s2_redirect", redirect_pc, 32'h0040_0040);
        chk("s2_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("s2_pred_target", pred_target, 32'h0040_0040);
        @(posedge clk);
        #1;
        chk("s2_pulse_end", {31'd0, mispredict}, 32'd0);

        // 3: train up to 11, then two not-takens
        resolve(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1);
        chk("s3_ok1", {31'd0, mispredict}, 32'd0);
        resolve(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1);
        chk("s3_ok2", {31'd0, mispredict}, 32'd0);
        resolve(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1);
        chk("s3_nt1_mis", {31'd0, mispredict}, 32'd1);
        chk("s3_nt1_redirect", redirect_pc, 32'h0040_0014);
        chk("s3_nt1_pred", {31'd0, pred_taken}, 32'd1);
        resolve(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1);
        chk("s3_nt2_mis_back2back", {31'd0, mispredict}, 32'd1);
        chk("s3_nt2_pred", {31'd0, pred_taken}, 32'd0);
        chk("s3_nt2_target", pred_target, 32'h0040_0014);
        @(posedge clk);
        #1;
        chk("s3_idle_mis", {31'd0, mispredict}, 32'd0);
        chk("s3_redirect_hold", redirect_pc, 32'h0040_0014);

        // 4: aliasing entry replacement
        fetch_pc = 32'h0040_0050;
        #1;
        chk("s4_alias_miss", {31'd0, pred_taken}, 32'd0);
        chk("s4_alias_target", pred_target, 32'h0040_0054);
        resolve(32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0054, 1'b1);
        chk("s4_alloc_mis", {31'd0, mispredict}, 32'd1);
        chk("s4_alloc_redirect", redirect_pc, 32'h0040_0100);
        chk("s4_new_pred", {31'd0, pred_taken}, 32'd1);
        chk("s4_new_target", pred_target, 32'h0040_0100);
        fetch_pc = 32'h0040_0010;
        #1;
        chk("s4_old_misses", {31'd0, pred_taken}, 32'd0);
        chk("s4_old_target", pred_target, 32'h0040_0014);

        // Wrong taken target with correct direction still mispredicts
        resolve(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100, 1'b1);
        chk("tgt_mis", {31'd0, mispredict}, 32'd1);
        chk("tgt_redirect", redirect_pc, 32'h0040_0200);
        fetch_pc = 32'h0040_0050;
        #1;
        chk("tgt_updated", pred_target, 32'h0040_0200);

        // Non-branch valid resolve: no training, no pulse
        resolve(32'h0040_0020, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0024, 1'b0);
        chk("nonbr_mis", {31'd0, mispredict}, 32'd0);
        chk("nonbr_redirect_hold", redirect_pc, 32'h0040_0200);
        fetch_pc = 32'h0040_0020;
        #1;
        chk("nonbr_no_alloc", {31'd0, pred_taken}, 32'd0);

        // Fall-through wraps at the top of the address space
        fetch_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_target", pred_target, 32'h0000_0000);

        // 5: same-cycle fetch and resolve, no bypass
        fetch_pc        = 32'h0040_0030;
        res_valid       = 1'b1;
        res_is_branch   = 1'b1;
        res_pc          = 32'h0040_0030;
        res_taken       = 1'b1;
        res_target      = 32'h0040_0080;
        res_pred_taken  = 1'b0;
        res_pred_target = 32'h0040_0034;
        #1;
        chk("s5_same_cycle", {31'd0, pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        res_valid     = 1'b0;
        res_is_branch = 1'b0;
        chk("s5_next_cycle", {31'd0, pred_taken}, 32'd1);
        chk("s5_mis_pending", {31'd0, mispredict}, 32'd1);

        // 6: asynchronous reset kills the pulse and clears the table
        rst = 1'b1;
        #1;
        chk("s6_rst_mis", {31'd0, mispredict}, 32'd0);
        chk("s6_rst_redirect", redirect_pc, 32'd0);
        chk("s6_rst_table", {31'd0, pred_taken}, 32'd0);
        fetch_pc = 32'h0040_0050;
        #1;
        chk("s6_rst_table2", {31'd0, pred_taken}, 32'd0);
`ifdef BP_STATS_EN
        chk("stat_rst_br", stat_branches, 32'd0);
        chk("stat_rst_mis", stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Three branches, one mispredict, plus an ignored non-branch
        resolve(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014, 1'b1);
        chk("st_b1_mis", {31'd0, mispredict}, 32'd1);
        resolve(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1);
        chk("st_b2_mis", {31'd0, mispredict}, 32'd0);
        resolve(32'h0040_0044, 1'b0, 32'h0040_0000, 1'b1, 32'h0040_0000, 1'b0);
        resolve(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b0, 32'h0040_0014, 1'b1);
        chk("st_b3_mis", {31'd0, mispredict}, 32'd0);
`ifdef BP_STATS_EN
        chk("stat_branches", stat_branches, 32'd3);
        chk("stat_mispredicts", stat_mispredicts, 32'd1);
`endif
        fetch_pc = 32'h0040_0010;
        #1;
        chk("st_ctr_after", {31'd0, pred_taken}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
